// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the LC-3b register file write port. In-order FIFO of
// {dest, data}, one commit per cycle, with a youngest-match bypass lookup.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [2:0]       wr_dest,
  input  logic [15:0]      wr_data,
  output logic             wr_ready,
  input  logic             rf_stall,
  output logic             rf_load,
  output logic [2:0]       rf_dest,
  output logic [15:0]      rf_data,
  input  logic [2:0]       lk_reg,
  output logic             lk_hit,
  output logic [15:0]      lk_data,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] C_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] C_EMPTY = (PTR_W+1)'(0);

  logic [2:0]       r_dest [DEPTH];
  logic [15:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_hit;
  logic [15:0]      w_lk_data;

  assign w_empty  = (r_count == C_EMPTY);
  assign wr_ready = (r_count != C_FULL);
  assign w_push   = wr_valid & wr_ready;
  assign w_pop    = ~w_empty & ~rf_stall;
  assign rf_load  = w_pop;
  assign rf_dest  = w_empty ? 3'd0 : r_dest[r_head];
  assign rf_data  = w_empty ? 16'd0 : r_data[r_head];
  assign count    = r_count;
  assign lk_hit   = w_hit;
  assign lk_data  = w_lk_data;

  // Entry storage; contents are irrelevant until the slot is occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_tail] <= wr_dest;
      r_data[r_tail] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= PTR_W'(0);
      r_tail  <= PTR_W'(0);
      r_count <= C_EMPTY;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk occupied slots oldest to youngest so the last match wins.
  always_comb begin
    w_hit     = 1'b0;
    w_lk_data = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit     = w_hit | (((PTR_W+1)'(i) < r_count) && (r_dest[r_head + PTR_W'(i)] == lk_reg));
      w_lk_data = (((PTR_W+1)'(i) < r_count) && (r_dest[r_head + PTR_W'(i)] == lk_reg))
                  ? r_data[r_head + PTR_W'(i)] : w_lk_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_valid;
  logic [2:0]       wr_dest;
  logic [15:0]      wr_data;
  logic             wr_ready;
  logic             rf_stall;
  logic             rf_load;
  logic [2:0]       rf_dest;
  logic [15:0]      rf_data;
  logic [2:0]       lk_reg;
  logic             lk_hit;
  logic [15:0]      lk_data;
  logic [PTR_W:0]   count;

  int checks   = 0;
  int failures = 0;

  logic [18:0] mq[$];
  logic [15:0] mrf [8];
  logic [2:0]  commit_log[$];

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_dest(wr_dest), .wr_data(wr_data), .wr_ready(wr_ready),
    .rf_stall(rf_stall), .rf_load(rf_load), .rf_dest(rf_dest), .rf_data(rf_data),
    .lk_reg(lk_reg), .lk_hit(lk_hit), .lk_data(lk_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_lookup(input logic [2:0] r);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i][18:16] == r) return {1'b1, mq[i][15:0]};
    return 17'd0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic [16:0] lk;
    lk = model_lookup(lk_reg);
    chk("count",    32'(count),    32'(mq.size()));
    chk("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
    chk("rf_load",  32'(rf_load),  32'((mq.size() != 0) && !rf_stall));
    chk("rf_dest",  32'(rf_dest),  (mq.size() != 0) ? 32'(mq[0][18:16]) : 32'd0);
    chk("rf_data",  32'(rf_data),  (mq.size() != 0) ? 32'(mq[0][15:0])  : 32'd0);
    chk("lk_hit",   32'(lk_hit),   32'(lk[16]));
    chk("lk_data",  32'(lk_data),  32'(lk[15:0]));
  end

  // Advance one clock edge, applying the spec rules to the model with the inputs seen there.
  task automatic step();
    bit pop;
    bit push;
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
      pop  = (mq.size() != 0) && !rf_stall;
      push = wr_valid && (mq.size() != DEPTH);
      if (pop) begin
        mrf[mq[0][18:16]] = mq[0][15:0];
        commit_log.push_back(mq[0][18:16]);
        void'(mq.pop_front());
      end
      if (push) mq.push_back({wr_dest, wr_data});
    end
    #1;
  endtask

  task automatic push_step(input logic [2:0] d, input logic [15:0] v);
    wr_valid = 1'b1;
    wr_dest  = d;
    wr_data  = v;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    mq.delete();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_dest = 3'd0; wr_data = 16'd0;
    rf_stall = 1'b0; lk_reg = 3'd0;
    for (int i = 0; i < 8; i++) mrf[i] = 16'd0;
    #1;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rf_load",  32'(rf_load),  32'd0);
    chk("rst_lk_hit",   32'(lk_hit),   32'd0);
    step();
    reset = 1'b0;

    // Async reset mid-operation with three queued entries.
    rf_stall = 1'b1;
    push_step(3'd1, 16'h0011);
    push_step(3'd2, 16'h0022);
    push_step(3'd3, 16'h0033);
    chk("pre_reset_count", 32'(count), 32'd3);
    rf_stall = 1'b0;
    lk_reg   = 3'd1;
    #1;
    reset = 1'b1;
    mq.delete();
    #1;
    chk("mid_rst_count",    32'(count),    32'd0);
    chk("mid_rst_rf_load",  32'(rf_load),  32'd0);
    chk("mid_rst_lk_hit",   32'(lk_hit),   32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;
    push_step(3'd2, 16'h1234);
    chk("lat_rf_load", 32'(rf_load), 32'd1);
    chk("lat_rf_dest", 32'(rf_dest), 32'd2);
    chk("lat_rf_data", 32'(rf_data), 32'h1234);
    step();
    chk("lat_commit_r2", 32'(mrf[2]), 32'h1234);
    chk("lat_count0",    32'(count),  32'd0);

    // Fill while stalled, hold a fifth request, then drain.
    commit_log.delete();
    rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_step(3'(i), 16'(i));
    chk("full_count",    32'(count),    32'd4);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_dest = 3'd5; wr_data = 16'h0005;
    step();
    step();
    chk("full_hold_count", 32'(count), 32'd4);
    rf_stall = 1'b0;
    step();
    chk("unstall_pop_only", 32'(count), 32'd3);
    step();
    chk("unstall_push_pop", 32'(count), 32'd3);
    wr_valid = 1'b0;
    step(); step(); step();
    chk("drain_count",   32'(count), 32'd0);
    chk("order_len",     32'(commit_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < commit_log.size(); i++)
      chk("order_dest", 32'(commit_log[i]), 32'(i + 1));

    // Repeated writes to the same register: bypass returns the youngest.
    rf_stall = 1'b1;
    push_step(3'd3, 16'hAAAA);
    push_step(3'd3, 16'hBBBB);
    lk_reg = 3'd3;
    #1;
    chk("byp_hit",  32'(lk_hit),  32'd1);
    chk("byp_data", 32'(lk_data), 32'hBBBB);
    lk_reg = 3'd5;
    #1;
    chk("byp_miss_hit",  32'(lk_hit),  32'd0);
    chk("byp_miss_data", 32'(lk_data), 32'd0);
    rf_stall = 1'b0;
    lk_reg   = 3'd3;
    step(); step();
    chk("byp_commit_r3", 32'(mrf[3]), 32'hBBBB);
    chk("byp_after_hit", 32'(lk_hit), 32'd0);

    // Streaming: push every cycle with no stall.
    commit_log.delete();
    for (int i = 0; i < 10; i++) begin
      push_step(3'(i % 8), 16'(i));
      chk("stream_count",    32'(count),    32'd1);
      chk("stream_wr_ready", 32'(wr_ready), 32'd1);
    end
    step();
    chk("stream_len", 32'(commit_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < commit_log.size(); i++)
      chk("stream_dest", 32'(commit_log[i]), 32'(i % 8));

    // Wrap: head moved to slot 3, three live entries straddle the wrap.
    pulse_reset();
    rf_stall = 1'b1;
    push_step(3'd6, 16'h1111);
    push_step(3'd6, 16'h2222);
    push_step(3'd6, 16'h3333);
    rf_stall = 1'b0;
    step(); step(); step();
    rf_stall = 1'b1;
    push_step(3'd6, 16'h4444);
    push_step(3'd2, 16'h5555);
    push_step(3'd6, 16'h6666);
    lk_reg = 3'd6;
    #1;
    chk("wrap_hit",  32'(lk_hit),  32'd1);
    chk("wrap_data", 32'(lk_data), 32'h6666);
    lk_reg = 3'd2;
    #1;
    chk("wrap_r2_data", 32'(lk_data), 32'h5555);
    rf_stall = 1'b0;
    lk_reg   = 3'd6;
    step();
    chk("wrap_after_pop", 32'(lk_data), 32'h6666);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      wr_valid = ($urandom_range(0, 99) < 60);
      wr_dest  = 3'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      rf_stall = ($urandom_range(0, 99) < 35);
      lk_reg   = 3'($urandom_range(0, 7));
      step();
    end
    wr_valid = 1'b0;
    rf_stall = 1'b0;
    for (int n = 0; n < DEPTH + 1; n++) step();
    chk("final_empty", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
